uart_tx: RTL and testbench
==========================

# uart_tx

Buffered UART transmitter: the serial-output counterpart of the SDRAM controller's UART receive path. It accepts bytes over a valid/ready handshake into a 4-entry FIFO and serializes each as an 8N1 frame (start, 8 data LSB-first, stop) on `tx` at `BAUD_RATE`. It sits beside `sdram_top` and returns SDRAM read data, or any status byte, to the host link.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, serial bit rate. Benches override it to a large value to shorten frames.
- `BAUD_DIV`, `CLK_FREQ/BAUD_RATE` (integer truncation, 5208 by default), clocks per bit. Derived; not overridden directly.
- `FIFO_DEPTH`, 4, byte FIFO entries. Must be a power of 2.

Ports:
- `sys_clk` in 1: system clock. This is the block's only clock.
- `sys_rst_n` in 1: reset, asynchronous assert, active-low.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: FIFO not full. A byte is accepted at a rising edge where `tx_valid && tx_ready`.
- `tx` out 1: serial line. Idles high.
- `tx_busy` out 1: high while the FSM is not IDLE.
- `fifo_cnt` out 3: number of occupied FIFO entries, 0 to 4.

## Operation
- **FIFO**
  - Push on `tx_valid && tx_ready`. `tx_ready = (fifo_cnt != FIFO_DEPTH)`, combinational from the registered count.
  - Pop when the FSM loads a byte.
  - Push and pop in the same cycle: `fifo_cnt` is unchanged and both take effect.
  - `tx_valid` while full is ignored; data is not overwritten.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **FSM states:** IDLE, START, DATA, STOP.
- **Baud counter:** `baud_cnt` runs 0 to `BAUD_DIV-1` in every non-IDLE state. `bit_end = (baud_cnt == BAUD_DIV-1)`. The counter clears on every state entry.
- **IDLE**
  - Drives `tx` = 1.
  - If `fifo_cnt != 0`: pop the head into `shift_reg`, go to START, and drive `tx` = 0 from the same edge.
- **START:** `tx` = 0. On `bit_end` go to DATA with `bit_idx` = 0.
- **DATA**
  - `tx` = `shift_reg[0]`.
  - On `bit_end`, shift right and increment `bit_idx`.
  - After bit 7's `bit_end`, go to STOP.
- **STOP**
  - `tx` = 1.
  - On `bit_end`, if `fifo_cnt != 0`, pop and go directly to START. There is no idle gap between frames.
  - Otherwise go to IDLE.
- **Output register:** `tx` is registered (glitch-free) and changes only on state or bit transitions.
- **Reset**
  - Reset mid-frame returns `tx` to 1 immediately, without waiting for a clock.
  - Reset discards the FIFO contents and the frame in progress. No partial stop bit is generated.
- **Reset values:** `tx` = 1, `tx_ready` = 1, `tx_busy` = 0, `fifo_cnt` = 0, state IDLE, `baud_cnt` = 0, pointers 0.

## Timing
- **Byte accepted into an empty FIFO with the FSM in IDLE, at edge E0:**
  - `fifo_cnt` = 1 after E0.
  - At E1 the FSM pops the byte, `tx` falls, and `tx_busy` rises.
- **Frame length:** exactly `10*BAUD_DIV` cycles. The start bit begins at E1 and the stop bit ends at E1 + `10*BAUD_DIV`.
- **Sustained throughput:** one byte per `10*BAUD_DIV` cycles while the FIFO is non-empty.
- **`tx_busy`:** falls at the edge where STOP exits to IDLE.
- **`tx_ready` latency:** deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the next pop.

## Test plan
Benches use `BAUD_RATE` = 5_000_000, so `BAUD_DIV` = 10.

1. **Reset:** hold `sys_rst_n` low for 5 cycles -> `tx`=1, `tx_ready`=1, `tx_busy`=0, `fifo_cnt`=0 during and after reset.
2. **Single byte:** push 0xA5 at E0 -> `tx` falls at E1. Line reads 0,1,0,1,0,0,1,0,1,1, each bit held exactly 10 cycles. `tx_busy` is high for exactly 100 cycles, then `tx` stays 1.
3. **Burst with stall:** hold `tx_valid` high with 6 bytes 0x00,0xFF,0x55,0xAA,0x3C,0x81 starting at E0.
   - Bytes 0 to 4 are accepted at E0 to E4; `fifo_cnt` reaches 4 and `tx_ready` drops after E4.
   - Byte 5 is accepted at E102, one cycle after the pop at E101.
   - Six contiguous frames: 600 cycles with no idle gap, decoded data matching in order.
4. **Full-FIFO ignore:** fill the FIFO while a frame is in progress, then drive `tx_valid` with 0xEE while `tx_ready`=0 -> 0xEE never appears on `tx`, and `fifo_cnt` stays 4.
5. **Reset mid-frame:** assert `sys_rst_n` low 37 cycles into a 0x3C frame while 2 bytes are queued.
   - `tx`=1 immediately and `fifo_cnt`=0.
   - After release with no new pushes, `tx` stays 1 for 200 cycles.
6. **Simultaneous push/pop:** push 0x12 on the exact edge where STOP exits with `fifo_cnt`=1 -> `fifo_cnt` stays 1, the next frame carries the old head, and the following frame carries 0x12.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter with a small byte FIFO and registered serial output
module uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4,
  localparam int BAUD_DIV  = CLK_FREQ / BAUD_RATE,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          tx,
  output logic          tx_busy,
  output logic [CW-1:0] fifo_cnt
);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] shift_reg, shift_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [BW-1:0] baud_cnt;
  logic bit_end, push, pop, tx_n;
  assign tx_ready = fifo_cnt != FULL;
  assign push = tx_valid && tx_ready;
  assign bit_end = baud_cnt == LAST;
  assign tx_busy = state != IDLE;
  assign pop = (state == IDLE || (state == STOP && bit_end)) && fifo_cnt != '0;
  always_comb begin
    state_n = state;
    shift_n = pop ? mem[rd_ptr] : shift_reg;
    bit_idx_n = bit_idx;
    case (state)
      IDLE:  state_n = pop ? START : IDLE;
      START: if (bit_end) begin
        state_n = DATA;
        bit_idx_n = '0;
      end
      DATA:  if (bit_end) begin
        shift_n = shift_reg >> 1;
        bit_idx_n = bit_idx + 3'd1;
        state_n = bit_idx == 3'd7 ? STOP : DATA;
      end
      STOP:  if (bit_end) state_n = pop ? START : IDLE;
      default: state_n = IDLE;
    endcase
    // the line level is decided from the next state so tx changes on the same edge as the state
    tx_n = state_n == DATA ? shift_n[0] : state_n != START;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      shift_reg <= '0;
      bit_idx <= '0;
      baud_cnt <= '0;
      tx <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_cnt <= '0;
    end else begin
      state <= state_n;
      shift_reg <= shift_n;
      bit_idx <= bit_idx_n;
      baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + BW'(1);
      tx <= tx_n;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  always_ff @(posedge sys_clk)
    if (push) mem[wr_ptr] <= tx_data;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed checks of uart_tx against a frame-timer reference model
module tb_uart_tx;
  localparam int DIV = 10;
  localparam int FRAME = 10 * DIV;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, tx, tx_busy;
  logic [2:0] fifo_cnt;
  int n_tests = 0;
  int n_fail = 0;
  int ncyc = 0;
  logic dut_acc;
  logic [7:0] q[$];
  logic m_active = 1'b0;
  int m_t = 0;
  logic [7:0] m_cur = '0;

  uart_tx #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .FIFO_DEPTH(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .fifo_cnt(fifo_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int t);
    int k;
    k = t / DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic model_reset();
    q.delete();
    m_active = 1'b0;
    m_t = 0;
  endtask

  // one clock edge of the reference: a frame is a 100-cycle timer, the FIFO a queue
  task automatic model_step(input logic v, input logic [7:0] d);
    logic push_m, can_pop;
    push_m = v && (q.size() != 4);
    can_pop = q.size() != 0;
    if (m_active && m_t != FRAME - 1) m_t++;
    else if (can_pop) begin
      m_cur = q.pop_front();
      m_t = 0;
      m_active = 1'b1;
    end else m_active = 1'b0;
    if (push_m) q.push_back(d);
  endtask

  task automatic check_outputs();
    check("tx", {31'd0, tx}, {31'd0, m_active ? frame_bit(m_cur, m_t) : 1'b1});
    check("busy", {31'd0, tx_busy}, {31'd0, m_active});
    check("cnt", {29'd0, fifo_cnt}, q.size());
    check("ready", {31'd0, tx_ready}, {31'd0, q.size() != 4});
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    tx_valid = v;
    tx_data = d;
    dut_acc = v && tx_ready;
    @(posedge sys_clk);
    if (!sys_rst_n) model_reset();
    else model_step(v, d);
    ncyc++;
    @(negedge sys_clk);
    check_outputs();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_active || q.size() != 0) && n < 1000) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    check("drain_done", {31'd0, m_active || q.size() != 0}, 32'd0);
    repeat (3) cycle(1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] burst [6];
    int e0, fall_at, busy_len, n;
    int acc_edge [6];
    burst = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h3C, 8'h81};
    @(negedge sys_clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    repeat (5) cycle(1'b0, 8'h00);
    sys_rst_n = 1'b1;
    repeat (3) cycle(1'b0, 8'h00);

    cycle(1'b1, 8'hA5);
    e0 = ncyc;
    fall_at = -1;
    busy_len = 0;
    repeat (120) begin
      cycle(1'b0, 8'h00);
      if (tx === 1'b0 && fall_at < 0) fall_at = ncyc - e0;
      if (tx_busy === 1'b1) busy_len++;
    end
    check("single_fall_edge", fall_at, 32'd1);
    check("single_busy_len", busy_len, FRAME);

    e0 = ncyc + 1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      do begin
        cycle(1'b1, burst[i]);
        n++;
      end while (!dut_acc && n < 300);
      acc_edge[i] = ncyc - e0;
    end
    check("burst_b4_edge", acc_edge[4], 32'd4);
    check("burst_b5_edge", acc_edge[5], 32'd102);
    drain();

    cycle(1'b1, 8'h11);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h20 + 8'(i));
    check("full_ready", {31'd0, tx_ready}, 32'd0);
    repeat (20) cycle(1'b1, 8'hEE);
    check("full_cnt", {29'd0, fifo_cnt}, 32'd4);
    drain();

    cycle(1'b1, 8'h3C);
    cycle(1'b1, 8'h01);
    cycle(1'b1, 8'h02);
    n = 0;
    while (!(m_active && m_t == 37) && n < 200) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    check("rst_mid_reached", {31'd0, m_active && m_t == 37}, 32'd1);
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_cnt", {29'd0, fifo_cnt}, 32'd0);
    check("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
    @(negedge sys_clk);
    repeat (2) cycle(1'b0, 8'h00);
    sys_rst_n = 1'b1;
    repeat (200) cycle(1'b0, 8'h00);

    cycle(1'b1, 8'hA1);
    cycle(1'b1, 8'hB2);
    n = 0;
    while (!(m_active && m_t == FRAME - 1) && n < 300) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    check("pp_cnt_before", {29'd0, fifo_cnt}, 32'd1);
    cycle(1'b1, 8'h12);
    check("pp_cnt_after", {29'd0, fifo_cnt}, 32'd1);
    drain();

    repeat (3000) cycle($urandom_range(0, 5) == 0, 8'($urandom));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
